// File: rtl/sig_mag_thr_sched.sv
// Adaptive magnitude-threshold scheduler for NCH sign/magnitude quantizer slices.
// Counts mag hits per window, then steps each channel's threshold with one shared unit.
module sig_mag_thr_sched #(
    parameter int               NCH      = 4,
    parameter int               THR_W    = 13,
    parameter int               CNT_W    = 10,
    parameter logic [THR_W-1:0] THR_INIT = '0,
    parameter int               TOL      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NCH-1:0]          mag,
    input  logic [1:0]              mode,
    input  logic [CNT_W:0]          target,
    input  logic [$clog2(NCH)-1:0]  man_ch,
    input  logic [THR_W-1:0]        man_thr,
    input  logic                    man_load,
    output logic [NCH*THR_W-1:0]    thr_out,
    output logic [NCH-1:0]          lock,
    output logic                    upd_done
);

    localparam int CH_W = $clog2(NCH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);
    localparam logic [CH_W:0]   NCH_L   = (CH_W+1)'(NCH);
    localparam logic [CNT_W:0]  TOL_L   = (CNT_W+1)'(TOL);

    typedef enum logic [1:0] {IDLE, UPD, DONE} state_t;

    state_t          state_q, state_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [CNT_W-1:0] win_cnt;
    logic            term;

    logic [CNT_W:0]   hits     [NCH];
    logic [CNT_W:0]   snap     [NCH];
    logic [THR_W-1:0] thr      [NCH];
    logic [1:0]       lock_cnt [NCH];

    logic [CNT_W:0]   cur_snap;
    logic [THR_W-1:0] cur_thr;
    logic [THR_W-1:0] unit_thr;
    logic [CNT_W:0]   diff;
    logic             gt, lt, in_tol;
    logic             man_wr;
    logic             auto_wr;

    assign term = &win_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt <= '0;
            state_q <= IDLE;
            ch_q    <= '0;
        end else begin
            win_cnt <= win_cnt + 1'b1;
            state_q <= state_d;
            ch_q    <= ch_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        upd_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (term) begin
                    state_d = UPD;
                    ch_d    = '0;
                end
            end
            UPD: begin
                if (ch_q == LAST_CH) begin
                    state_d = DONE;
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
            DONE: begin
                upd_done = 1'b1;
                // A back-to-back window can close while DONE is still showing
                if (term) begin
                    state_d = UPD;
                    ch_d    = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shared compare/step unit, time-multiplexed over the channels
    always_comb begin
        cur_snap = snap[ch_q];
        cur_thr  = thr[ch_q];
        gt       = cur_snap > target;
        lt       = cur_snap < target;
        diff     = gt ? (cur_snap - target) : (target - cur_snap);
        in_tol   = diff <= TOL_L;
        unit_thr = cur_thr;
        if (gt && (cur_thr != '1)) begin
            unit_thr = cur_thr + 1'b1;
        end else if (lt && (cur_thr != '0)) begin
            unit_thr = cur_thr - 1'b1;
        end
    end

    assign man_wr  = man_load && (mode == 2'd2) && ({1'b0, man_ch} < NCH_L);
    assign auto_wr = (state_q == UPD) && (mode == 2'd0);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        localparam logic [CH_W-1:0] KI = CH_W'(k);
        logic sel;

        assign sel = (state_q == UPD) && (ch_q == KI);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                hits[k] <= '0;
                snap[k] <= '0;
            end else if (term) begin
                snap[k] <= hits[k] + (CNT_W+1)'(mag[k]);
                hits[k] <= '0;
            end else begin
                hits[k] <= hits[k] + (CNT_W+1)'(mag[k]);
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                thr[k] <= THR_INIT;
            end else if (man_wr && (man_ch == KI)) begin
                thr[k] <= man_thr;
            end else if (auto_wr && sel) begin
                thr[k] <= unit_thr;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                lock_cnt[k] <= '0;
            end else if (sel) begin
                if (in_tol) begin
                    lock_cnt[k] <= (lock_cnt[k] == 2'd3) ? 2'd3 : lock_cnt[k] + 2'd1;
                end else begin
                    lock_cnt[k] <= '0;
                end
            end
        end

        assign thr_out[k*THR_W +: THR_W] = thr[k];
        assign lock[k] = &lock_cnt[k];
    end

endmodule

// File: tb/tb_sig_mag_thr_sched.sv
// Bench for sig_mag_thr_sched: directed scenarios plus random traffic,
// checked against a per-window hit-count model of the threshold scheduler.
module tb_sig_mag_thr_sched;

    localparam int NCH   = 4;
    localparam int THR_W = 13;
    localparam int CNT_W = 10;
    localparam int TOL   = 8;
    localparam int WIN   = 1 << CNT_W;
    localparam int TMAX  = (1 << THR_W) - 1;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NCH-1:0]         mag;
    logic [1:0]             mode;
    logic [CNT_W:0]         target;
    logic [1:0]             man_ch;
    logic [THR_W-1:0]       man_thr;
    logic                   man_load;
    logic [NCH*THR_W-1:0]   thr_out;
    logic [NCH-1:0]         lock;
    logic                   upd_done;

    sig_mag_thr_sched dut (
        .clk      (clk),
        .reset    (reset),
        .mag      (mag),
        .mode     (mode),
        .target   (target),
        .man_ch   (man_ch),
        .man_thr  (man_thr),
        .man_load (man_load),
        .thr_out  (thr_out),
        .lock     (lock),
        .upd_done (upd_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int m_thr  [NCH];
    int m_lk   [NCH];
    int m_cnt  [NCH];
    int m_snap [NCH];
    int pos;
    bit pass_on;

    int pct [NCH];
    int exact1;
    bit rnd_mode, rnd_man, rnd_tgt;
    int saved [NCH];
    int n;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [NCH*THR_W-1:0] pack_thr();
        logic [NCH*THR_W-1:0] v;
        v = '0;
        for (int k = 0; k < NCH; k++) v[k*THR_W +: THR_W] = THR_W'(m_thr[k]);
        return v;
    endfunction

    function automatic logic [NCH-1:0] pack_lock();
        logic [NCH-1:0] v;
        for (int k = 0; k < NCH; k++) v[k] = (m_lk[k] == 3);
        return v;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < NCH; k++) begin
            m_thr[k]  = 0;
            m_lk[k]   = 0;
            m_cnt[k]  = 0;
            m_snap[k] = 0;
        end
        pos     = 0;
        pass_on = 0;
    endtask

    // One clock: advance the model by the rules, then compare outputs
    task automatic tick();
        int ch, tg, s, d;
        @(posedge clk);
        if (pass_on && pos < NCH) begin
            ch = pos;
            tg = int'(target);
            s  = m_snap[ch];
            if (mode == 2'd0) begin
                if (s > tg && m_thr[ch] < TMAX) m_thr[ch]++;
                else if (s < tg && m_thr[ch] > 0) m_thr[ch]--;
            end
            d = (s > tg) ? s - tg : tg - s;
            m_lk[ch] = (d <= TOL) ? ((m_lk[ch] == 3) ? 3 : m_lk[ch] + 1) : 0;
        end
        if (pass_on && pos == NCH) pass_on = 0;
        for (int k = 0; k < NCH; k++) begin
            if (pos == WIN - 1) begin
                m_snap[k] = m_cnt[k] + int'(mag[k]);
                m_cnt[k]  = 0;
            end else begin
                m_cnt[k] += int'(mag[k]);
            end
        end
        if (pos == WIN - 1) pass_on = 1;
        if (man_load && mode == 2'd2) m_thr[man_ch] = int'(man_thr);
        pos = (pos + 1) % WIN;
        #1;
        chk("upd_done", 64'(upd_done), 64'(pass_on && pos == NCH));
        if (pass_on && pos == NCH) begin
            chk("thr_at_done", 64'(thr_out), 64'(pack_thr()));
            chk("lock_at_done", 64'(lock), 64'(pack_lock()));
        end
    endtask

    task automatic drive();
        for (int k = 0; k < NCH; k++) begin
            if (k == 1 && exact1 > 0) mag[k] = (pos < exact1 - 1) || (pos == WIN - 1);
            else mag[k] = ($urandom_range(99) < pct[k]);
        end
        if (rnd_mode && $urandom_range(19) == 0) mode = 2'($urandom_range(3));
        if (rnd_man) begin
            man_load = ($urandom_range(49) == 0);
            man_ch   = 2'($urandom_range(3));
            man_thr  = THR_W'($urandom_range(TMAX));
        end
        if (rnd_tgt && pos == 500) begin
            if ($urandom_range(4) == 0) target = 11'($urandom_range(1025, 2047));
            else target = 11'($urandom_range(250, 420));
        end
    endtask

    task automatic run(input int cyc);
        repeat (cyc) begin
            drive();
            tick();
        end
    endtask

    task automatic to_done(output int cnt);
        cnt = 0;
        do begin
            drive();
            tick();
            cnt++;
        end while (!(pass_on && pos == NCH) && cnt < 3 * WIN);
        chk("pass_reached", 64'(cnt < 3 * WIN), 64'(1));
    endtask

    task automatic run_to_pos(input int p);
        int cnt;
        cnt = 0;
        while (pos != p && cnt < 2 * WIN) begin
            drive();
            tick();
            cnt++;
        end
    endtask

    task automatic man(input int ch, input int val);
        mode     = 2'd2;
        man_load = 1'b1;
        man_ch   = 2'(ch);
        man_thr  = THR_W'(val);
        drive();
        tick();
        man_load = 1'b0;
        chk("man_load", 64'(thr_out[ch*THR_W +: THR_W]), 64'(val));
    endtask

    initial begin
        reset    = 1'b1;
        mag      = '0;
        mode     = 2'd0;
        target   = 11'd338;
        man_ch   = '0;
        man_thr  = '0;
        man_load = 1'b0;
        exact1   = 0;
        rnd_mode = 0;
        rnd_man  = 0;
        rnd_tgt  = 0;
        for (int k = 0; k < NCH; k++) pct[k] = 0;
        m_reset();
        #1;
        chk("rst_thr", 64'(thr_out), 64'(0));
        chk("rst_lock", 64'(lock), 64'(0));
        chk("rst_done", 64'(upd_done), 64'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Preload thresholds, then decrement toward and hold at zero
        run(100);
        man(0, 8190);
        man(1, 5);
        man(2, 2);
        man(3, 1000);
        mode = 2'd0;
        repeat (3) to_done(n);
        chk("dec_ch1", 64'(thr_out[1*THR_W +: THR_W]), 64'(2));
        chk("sat0_ch2", 64'(thr_out[2*THR_W +: THR_W]), 64'(0));

        // Constant mag on ch0 saturates at the top
        man(0, 8190);
        mode   = 2'd0;
        pct[0] = 100;
        repeat (3) to_done(n);
        chk("satmax_ch0", 64'(thr_out[0 +: THR_W]), 64'(TMAX));

        // Exactly on-target ch1 locks after 4 passes; 400 hits breaks it
        man(1, 50);
        mode   = 2'd0;
        exact1 = 338;
        repeat (4) to_done(n);
        chk("lock1_set", 64'(lock[1]), 64'(1));
        exact1 = 400;
        to_done(n);
        chk("lock1_clr", 64'(lock[1]), 64'(0));
        exact1 = 0;

        // Manual load at T+3 in mode 2 wins and holds through the pass
        mode = 2'd2;
        run_to_pos(2);
        man_load = 1'b1;
        man_ch   = 2'd2;
        man_thr  = 13'd100;
        drive();
        tick();
        man_load = 1'b0;
        chk("man_t3", 64'(thr_out[2*THR_W +: THR_W]), 64'(100));
        to_done(n);
        chk("man_hold", 64'(thr_out[2*THR_W +: THR_W]), 64'(100));

        // Same strobe in mode 0 is ignored
        mode = 2'd0;
        run_to_pos(2);
        man_load = 1'b1;
        man_ch   = 2'd2;
        man_thr  = 13'd200;
        drive();
        tick();
        man_load = 1'b0;
        chk("man_ign", 64'(thr_out[2*THR_W +: THR_W]), 64'(99));

        // Freeze for 3 windows: thresholds hold, passes still pulse
        for (int k = 0; k < NCH; k++) saved[k] = m_thr[k];
        mode   = 2'd1;
        pct[3] = 100;
        repeat (3) to_done(n);
        for (int k = 0; k < NCH; k++)
            chk("freeze_thr", 64'(thr_out[k*THR_W +: THR_W]), 64'(saved[k]));

        // Random traffic with mode changes, manual loads and target moves
        for (int k = 0; k < NCH; k++) pct[k] = 30 + 2 * k;
        rnd_mode = 1;
        rnd_man  = 1;
        rnd_tgt  = 1;
        run(6 * WIN);
        rnd_mode = 0;
        rnd_man  = 0;
        rnd_tgt  = 0;
        man_load = 1'b0;
        mode     = 2'd0;

        // Reset at T+2 aborts the pass; the next one arrives on schedule
        run_to_pos(1);
        drive();
        #2;
        reset = 1'b1;
        m_reset();
        #1;
        chk("abort_thr", 64'(thr_out), 64'(0));
        chk("abort_lock", 64'(lock), 64'(0));
        chk("abort_done", 64'(upd_done), 64'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        to_done(n);
        chk("abort_next", 64'(n), 64'(WIN + NCH));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
